// File: rtl/comp_mult_dbg_pkg.sv
// Shared definitions for the complex-multiplier stimulus generator:
// FSM state encoding, LFSR feedback polynomial and operand mode codes.
package comp_mult_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } gen_state_e;

  // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  localparam logic [1:0] MODE_LFSR   = 2'd0;
  localparam logic [1:0] MODE_RAMP   = 2'd1;
  localparam logic [1:0] MODE_CORNER = 2'd2;
  localparam logic [1:0] MODE_RSVD   = 2'd3;

  localparam logic [1:0] CIDX_MIN  = 2'd0;
  localparam logic [1:0] CIDX_MAX  = 2'd1;
  localparam logic [1:0] CIDX_MIX  = 2'd2;
  localparam logic [1:0] CIDX_ZERO = 2'd3;

  function automatic logic [31:0] lfsr_step(
    input logic [31:0] s
  );
    lfsr_step = {1'b0, s[31:1]}
              ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/comp_mult_lfsr.sv
// 32-bit Galois LFSR with synchronous load and step enable.
// Ports: clk, rst_n, load (reload seed), advance (one step), state.
module comp_mult_lfsr
  import comp_mult_dbg_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_2A5F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        advance,
  output logic [31:0] state
);

  // an all-zero state would lock the register
  localparam logic [31:0] INIT =
    (SEED == 32'h0) ? 32'h1 : SEED;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
    end else if (load) begin
      state <= INIT;
    end else if (advance) begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/comp_mult_stim_gen.sv
// Operand stimulus generator for a complex multiplier (LFSR/ramp/corner).
// Ports: clk, rst_n, sw_rst, start, num_ops, mode, op_val/op_rdy/op_data, busy, done, sent_cnt.
module comp_mult_stim_gen
  import comp_mult_dbg_pkg::*;
#(
  parameter int          DWIDTH = 8,
  parameter logic [31:0] SEED   = 32'hACE1_2A5F
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sw_rst,
  input  logic                  start,
  input  logic [15:0]           num_ops,
  input  logic [1:0]            mode,
  output logic                  op_val,
  input  logic                  op_rdy,
  output logic [4*DWIDTH-1:0]   op_data,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           sent_cnt
);

  localparam logic [DWIDTH-1:0] VMIN =
    {1'b1, {(DWIDTH-1){1'b0}}};
  localparam logic [DWIDTH-1:0] VMAX =
    {1'b0, {(DWIDTH-1){1'b1}}};

  gen_state_e  state_q;
  gen_state_e  state_d;
  logic [15:0] nops_q;
  logic [1:0]  mode_q;
  logic [1:0]  cidx_q;
  logic [31:0] lfsr;
  logic        hs;
  logic        last_hs;
  logic        lfsr_load;

  // sw_rst masks any handshake in the same cycle
  assign hs = (state_q == ST_RUN) & op_rdy & ~sw_rst;

  assign last_hs = hs & (nops_q != 16'h0)
                 & (16'(sent_cnt + 16'd1) == nops_q);

  // keep the LFSR parked at the seed outside RUN
  assign lfsr_load = sw_rst | (state_q != ST_RUN);

  comp_mult_lfsr #(
    .SEED(SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (lfsr_load),
    .advance(hs),
    .state  (lfsr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (sw_rst) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (start) state_d = ST_RUN;
        ST_RUN:  if (last_hs) state_d = ST_DONE;
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sent_cnt <= 16'h0;
      nops_q   <= 16'h0;
      mode_q   <= MODE_LFSR;
      cidx_q   <= CIDX_MIN;
    end else if (sw_rst) begin
      sent_cnt <= 16'h0;
      cidx_q   <= CIDX_MIN;
    end else if (state_q == ST_IDLE) begin
      cidx_q <= CIDX_MIN;
      if (start) begin
        sent_cnt <= 16'h0;
        nops_q   <= num_ops;
        mode_q   <= mode;
      end
    end else if (hs) begin
      sent_cnt <= sent_cnt + 16'd1;
      cidx_q   <= cidx_q + 2'd1;
    end
  end

  always_comb begin
    op_val  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    op_data = '0;
    unique case (state_q)
      ST_RUN: begin
        op_val = 1'b1;
        busy   = 1'b1;
        unique case (mode_q)
          MODE_RAMP:
            op_data = {4{sent_cnt[DWIDTH-1:0]}};
          MODE_CORNER: begin
            unique case (cidx_q)
              CIDX_MIN: op_data = {4{VMIN}};
              CIDX_MAX: op_data = {4{VMAX}};
              CIDX_MIX:
                op_data = {VMIN, VMAX, VMAX, VMIN};
              default:  op_data = '0;
            endcase
          end
          default:
            op_data = lfsr[4*DWIDTH-1:0];
        endcase
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_comp_mult_stim_gen.sv
// Directed self-checking bench for comp_mult_stim_gen (DWIDTH=8).
// Drives and samples 1ns after each rising edge.
module tb_comp_mult_stim_gen;

  logic        clk;
  logic        rst_n;
  logic        sw_rst;
  logic        start;
  logic [15:0] num_ops;
  logic [1:0]  mode;
  logic        op_val;
  logic        op_rdy;
  logic [31:0] op_data;
  logic        busy;
  logic        done;
  logic [15:0] sent_cnt;

  int checks;
  int failures;
  logic [15:0] exp_cnt;
  logic [7:0]  k;

  comp_mult_stim_gen dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sw_rst  (sw_rst),
    .start   (start),
    .num_ops (num_ops),
    .mode    (mode),
    .op_val  (op_val),
    .op_rdy  (op_rdy),
    .op_data (op_data),
    .busy    (busy),
    .done    (done),
    .sent_cnt(sent_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    sw_rst   = 1'b0;
    start    = 1'b0;
    num_ops  = 16'd0;
    mode     = 2'd0;
    op_rdy   = 1'b0;
    #12;
    chk("rst_val",  {31'b0, op_val}, 32'd0);
    chk("rst_data", op_data, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_cnt",  {16'b0, sent_cnt}, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // corner mode, 5 operands
    start = 1'b1; num_ops = 16'd5; mode = 2'd2;
    op_rdy = 1'b1;
    step();
    start = 1'b0; num_ops = 16'd9; mode = 2'd1;
    chk("cor_val", {31'b0, op_val}, 32'd1);
    chk("cor_d0", op_data, 32'h8080_8080);
    step();
    chk("cor_d1", op_data, 32'h7F7F_7F7F);
    step();
    chk("cor_d2", op_data, 32'h807F_7F80);
    step();
    chk("cor_d3", op_data, 32'h0000_0000);
    step();
    chk("cor_d4", op_data, 32'h8080_8080);
    chk("cor_busy", {31'b0, busy}, 32'd1);
    step();
    chk("cor_val0", {31'b0, op_val}, 32'd0);
    chk("cor_done", {31'b0, done}, 32'd1);
    chk("cor_cnt",  {16'b0, sent_cnt}, 32'd5);
    chk("cor_dz",   op_data, 32'd0);
    step();
    chk("cor_done0", {31'b0, done}, 32'd0);
    chk("cor_hold",  {16'b0, sent_cnt}, 32'd5);

    // LFSR mode with stalled consumer
    start = 1'b1; num_ops = 16'd4; mode = 2'd0;
    op_rdy = 1'b0;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_val", {31'b0, op_val}, 32'd1);
      chk("stall_d", op_data, 32'hACE1_2A5F);
      chk("stall_cnt", {16'b0, sent_cnt}, 32'd0);
      if (i < 2) step();
    end
    op_rdy = 1'b1;
    step();
    chk("lfsr_d1", op_data, 32'hD650_952C);
    chk("lfsr_cnt1", {16'b0, sent_cnt}, 32'd1);
    step();
    step();
    step();
    chk("lfsr_done", {31'b0, done}, 32'd1);
    chk("lfsr_cnt", {16'b0, sent_cnt}, 32'd4);
    step();

    // ramp mode, 300 operands
    start = 1'b1; num_ops = 16'd300; mode = 2'd1;
    step();
    start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      k = 8'(i);
      chk("ramp_d", op_data, {4{k}});
      step();
    end
    chk("ramp_done", {31'b0, done}, 32'd1);
    chk("ramp_cnt", {16'b0, sent_cnt}, 32'd300);
    step();

    // software reset mid-run
    start = 1'b1; num_ops = 16'd10; mode = 2'd1;
    step();
    start = 1'b0;
    step(); step(); step();
    chk("sw_pre", {16'b0, sent_cnt}, 32'd3);
    sw_rst = 1'b1;
    step();
    sw_rst = 1'b0;
    chk("sw_val",  {31'b0, op_val}, 32'd0);
    chk("sw_cnt",  {16'b0, sent_cnt}, 32'd0);
    chk("sw_done", {31'b0, done}, 32'd0);
    chk("sw_busy", {31'b0, busy}, 32'd0);
    step();
    chk("sw_done2", {31'b0, done}, 32'd0);
    start = 1'b1; num_ops = 16'd2; mode = 2'd0;
    step();
    start = 1'b0;
    chk("sw_seed", op_data, 32'hACE1_2A5F);
    step(); step();
    chk("sw_run_done", {31'b0, done}, 32'd1);
    step();

    // continuous run, random ready, stray starts
    start = 1'b1; num_ops = 16'd0; mode = 2'd1;
    op_rdy = 1'b0;
    step();
    exp_cnt = 16'd0;
    for (int i = 0; i < 200; i++) begin
      start  = 1'($urandom_range(0, 1));
      num_ops = 16'd1;
      op_rdy = 1'($urandom_range(0, 1));
      if (op_rdy) exp_cnt = exp_cnt + 16'd1;
      step();
      chk("cont_cnt", {16'b0, sent_cnt}, {16'b0, exp_cnt});
      chk("cont_bd", {30'b0, busy, done}, 32'd2);
    end
    start  = 1'b0;
    op_rdy = 1'b1;
    while (exp_cnt != 16'hFFFF) begin
      exp_cnt = exp_cnt + 16'd1;
      step();
      chk("cont_bd", {30'b0, busy, done}, 32'd2);
    end
    chk("wrap_ffff", {16'b0, sent_cnt}, 32'h0000_FFFF);
    chk("wrap_dff", op_data, 32'hFFFF_FFFF);
    step();
    chk("wrap_0", {16'b0, sent_cnt}, 32'd0);
    chk("wrap_bd", {30'b0, busy, done}, 32'd2);
    chk("wrap_d0", op_data, 32'd0);
    step();
    chk("wrap_1", {16'b0, sent_cnt}, 32'd1);
    chk("wrap_d1", op_data, 32'h0101_0101);

    // asynchronous reset mid-run
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_val",  {31'b0, op_val}, 32'd0);
    chk("ar_data", op_data, 32'd0);
    chk("ar_busy", {31'b0, busy}, 32'd0);
    chk("ar_cnt",  {16'b0, sent_cnt}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("ar_idle", {31'b0, op_val}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/comp_mult_stim_gen.md
COMP_MULT_STIM_GEN -- requirements
Module: comp_mult_stim_gen

Interface
REQ-001 SHALL have parameter DWIDTH, default 8, operand width in bits; legal range 2..8.
REQ-002 SHALL have parameter SEED, default 32'hACE1_2A5F, LFSR load value; a zero SEED SHALL load 32'h1.
REQ-003 SHALL have port clk  in  1  system clock.
REQ-004 SHALL have port rst_n  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have port sw_rst  in  1  synchronous software reset, active high.
REQ-006 SHALL have port start  in  1  run request pulse.
REQ-007 SHALL have port num_ops  in  16  operands per run; 0 = continuous.
REQ-008 SHALL have port mode  in  2  operand source: 0 LFSR, 1 ramp, 2 corner, 3 reserved (treated as 0).
REQ-009 SHALL have port op_val  out  1  operand valid.
REQ-010 SHALL have port op_rdy  in  1  multiplier ready.
REQ-011 SHALL have port op_data  out  4*DWIDTH  operands {x1,y1,x2,y2}, two's complement.
REQ-012 SHALL have port busy  out  1  high in RUN.
REQ-013 SHALL have port done  out  1  one-cycle end-of-run pulse.
REQ-014 SHALL have port sent_cnt  out  16  accepted-operand count, this run.

Function
REQ-015 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-016 IDLE: start SHALL latch num_ops and mode, clear sent_cnt, go RUN; op_val=1 with first operand in the next cycle.
REQ-017 RUN: op_val SHALL stay 1; a handshake is op_val & op_rdy at a rising clk edge.
REQ-018 op_data SHALL stay stable while op_val & ~op_rdy; the next operand SHALL appear the cycle after a handshake.
REQ-019 Each handshake SHALL increment sent_cnt (16-bit wrap).
REQ-020 Handshake with sent_cnt+1 == latched num_ops (num_ops != 0) SHALL go DONE; op_val=0 and done=1 in that next cycle.
REQ-021 DONE SHALL last exactly one cycle, then IDLE; sent_cnt holds its final value until next start.
REQ-022 start in RUN or DONE SHALL be ignored; num_ops/mode changes during RUN SHALL be ignored.
REQ-023 num_ops=0: RUN SHALL continue until sw_rst or rst_n.
REQ-024 Mode 0: op_data = LFSR[4*DWIDTH-1:0]; 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1, advances one step per handshake; first operand of every run uses SEED state.
REQ-025 Mode 1: op_data = {k,k,k,k}, k = sent_cnt[DWIDTH-1:0] (wraps modulo 2^DWIDTH).
REQ-026 Mode 2: op_data cycles index 0..3 per handshake, wrapping: 0 all MIN (-2^(DWIDTH-1)), 1 all MAX, 2 {MIN,MAX,MAX,MIN}, 3 all zero; index restarts at 0 each run.
REQ-027 op_data SHALL be 0 whenever op_val=0.

Reset
REQ-028 rst_n low SHALL force IDLE, op_val=0, op_data=0, busy=0, done=0, sent_cnt=0, LFSR=SEED, corner index=0.
REQ-029 sw_rst SHALL do the same synchronously, from any state, overriding start and handshakes in the same cycle.
REQ-030 A handshake coinciding with sw_rst SHALL not be counted.

Structure
REQ-031 Shared package/header comp_mult_dbg_pkg SHALL hold FSM state encoding, LFSR polynomial constant and mode codes.
REQ-032 LFSR SHALL be a sub-module comp_mult_lfsr (load, advance, 32-bit state out).

Verification
REQ-033 Reset: rst_n low mid-run -> op_val=0, op_data=0, busy=0, sent_cnt=0 immediately.
REQ-034 DWIDTH=8, mode=2, num_ops=5, op_rdy=1 -> op_data 80808080, 7F7F7F7F, 807F7F80, 00000000, 80808080; then op_val=0, done pulse, sent_cnt=5.
REQ-035 mode=0, op_rdy low 3 cycles after start -> op_val=1, op_data=SEED[31:0] stable all 3 cycles; sent_cnt=0 until op_rdy rises.
REQ-036 mode=1, num_ops=300, op_rdy=1 -> k runs 0..255 then 0..43; done after 300th handshake; sent_cnt=300.
REQ-037 sw_rst after 3 handshakes (num_ops=10) -> next cycle IDLE, op_val=0, sent_cnt=0, no done; restart mode 0 -> first op_data=SEED[31:0].
REQ-038 num_ops=0, random op_rdy, extra start pulses in RUN -> no done, busy stays 1, sent_cnt wraps FFFF->0000.
